// File: rtl/wb_backdoor_xbar_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_backdoor_xbar_if
// Purpose  : Bus bundle for the debug-backdoor Wishbone crossbar. Carries the
//            host-side classic Wishbone signals and the shared/one-hot slave
//            side signals.
// Ports    : none (signal bundle only)
//   modport slave  : the crossbar's view (host inputs in, responses out,
//                    drives the slave-side request signals)
//   modport master : the surrounding system's view (host + slave models)
// Revision : 1.0 - initial release
// ============================================================================
interface wb_backdoor_xbar_if #(
    parameter int N_SLAVES = 4
);
    // host side
    logic [31:0]            wb_data_i;
    logic [31:0]            wb_addr_i;
    logic                   wb_cyc_i;
    logic                   wb_strobe_i;
    logic                   wb_we_i;
    logic [31:0]            wb_data_o;
    logic                   wb_ack_o;
    logic                   wb_err_o;
    // slave side
    logic [N_SLAVES-1:0]    s_cyc_o;
    logic [N_SLAVES-1:0]    s_strobe_o;
    logic                   s_we_o;
    logic [31:0]            s_addr_o;
    logic [31:0]            s_data_o;
    logic [N_SLAVES*32-1:0] s_data_i;
    logic [N_SLAVES-1:0]    s_ack_i;

    modport slave (
        input  wb_data_i, wb_addr_i, wb_cyc_i, wb_strobe_i, wb_we_i,
        output wb_data_o, wb_ack_o, wb_err_o,
        output s_cyc_o, s_strobe_o, s_we_o, s_addr_o, s_data_o,
        input  s_data_i, s_ack_i
    );

    modport master (
        output wb_data_i, wb_addr_i, wb_cyc_i, wb_strobe_i, wb_we_i,
        input  wb_data_o, wb_ack_o, wb_err_o,
        input  s_cyc_o, s_strobe_o, s_we_o, s_addr_o, s_data_o,
        output s_data_i, s_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_backdoor_xbar.sv
`default_nettype none
// ============================================================================
// Module   : wb_backdoor_xbar
// Purpose  : Registered 1-master / N_SLAVES-slave classic Wishbone interconnect
//            for the debug backdoor into memory instances. Decodes
//            wb_addr_i[SEL_LSB +: SEL_W], forwards the cycle to one slave and
//            returns a registered one-cycle ack (or err for unmapped selects).
// Ports    : clock   - system clock, rising edge
//            reset_n - asynchronous active-low reset
//            bus     - wb_backdoor_xbar_if.slave (host + slave-side signals)
// Config   : `define WB_XBAR_TIMEOUT_EN enables a watchdog that aborts a
//            slave which has not acked within TIMEOUT WAIT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module wb_backdoor_xbar #(
    parameter int N_SLAVES = 4,
    parameter int SEL_LSB  = 16,
    parameter int SEL_W    = 2,
    parameter int TIMEOUT  = 255,
    parameter int CNT_W    = 8
) (
    input wire                clock,
    input wire                reset_n,
    wb_backdoor_xbar_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_idx, w_idx_nxt;
    logic [N_SLAVES-1:0] r_oh, w_oh_nxt;      // drives both s_cyc_o and s_strobe_o
    logic                r_we, w_we_nxt;
    logic [31:0]         r_addr, w_addr_nxt;
    logic [31:0]         r_wdata, w_wdata_nxt;
    logic [31:0]         r_rdata, w_rdata_nxt;
    logic                r_ack, w_ack_nxt;
    logic                r_err, w_err_nxt;

    logic [SEL_W-1:0]    w_sel;
    logic [N_SLAVES-1:0] w_dec;      // one-hot decode of the incoming select; 0 if unmapped
    logic                w_sel_ack;  // ack from the slave currently addressed
    logic [31:0]         w_sel_data;

`ifdef WB_XBAR_TIMEOUT_EN
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
`else
    logic                w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT > 0) && (CNT_W > 0);
`endif

    assign w_sel = bus.wb_addr_i[SEL_LSB +: SEL_W];

    // Select decode and return-path muxes. Selects >= N_SLAVES match no
    // slave, so an all-zero decode marks an unmapped access.
    always_comb begin
        w_dec      = '0;
        w_sel_ack  = 1'b0;
        w_sel_data = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (w_sel == SEL_W'(k)) begin
                w_dec[k] = 1'b1;
            end
            if (r_idx == SEL_W'(k)) begin
                w_sel_ack  = bus.s_ack_i[k];
                w_sel_data = bus.s_data_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_oh_nxt    = r_oh;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_rdata_nxt = '0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef WB_XBAR_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_strobe_i) begin
                    w_addr_nxt  = bus.wb_addr_i;
                    w_wdata_nxt = bus.wb_data_i;
                    w_we_nxt    = bus.wb_we_i;
                    w_idx_nxt   = w_sel;
                    if (|w_dec) begin
                        w_oh_nxt    = w_dec;
                        w_state_nxt = S_WAIT;
`ifdef WB_XBAR_TIMEOUT_EN
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.wb_cyc_i) begin
                    // host abandoned the cycle: silently drop it
                    w_oh_nxt    = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_sel_ack) begin
                    w_oh_nxt    = '0;
                    w_rdata_nxt = r_we ? 32'd0 : w_sel_data;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end
`ifdef WB_XBAR_TIMEOUT_EN
                // counter holds the number of WAIT cycles already elapsed,
                // so this is the TIMEOUT-th cycle without an ack
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_oh_nxt    = '0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
`endif
            end
            S_RESP: begin
                // ack/err/rdata fall back to their zero defaults here
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_oh    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
`ifdef WB_XBAR_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_oh    <= w_oh_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_rdata <= w_rdata_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
`ifdef WB_XBAR_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign bus.wb_data_o  = r_rdata;
    assign bus.wb_ack_o   = r_ack;
    assign bus.wb_err_o   = r_err;
    assign bus.s_cyc_o    = r_oh;
    assign bus.s_strobe_o = r_oh;
    assign bus.s_we_o     = r_we;
    assign bus.s_addr_o   = r_addr;
    assign bus.s_data_o   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_wb_backdoor_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_backdoor_xbar
// Purpose  : Self-checking bench for wb_backdoor_xbar (N_SLAVES=3, TIMEOUT=4).
//            Directed cases plus randomized transactions, each checked
//            against a transaction-level expectation derived from the
//            select/latency/abort rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_backdoor_xbar;

    localparam int N       = 3;
    localparam int SEL_LSB = 16;
    localparam int TOUT    = 4;

    logic clock;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    wb_backdoor_xbar_if #(.N_SLAVES(N)) bus ();

    wb_backdoor_xbar #(
        .N_SLAVES (N),
        .SEL_LSB  (SEL_LSB),
        .SEL_W    (2),
        .TIMEOUT  (TOUT),
        .CNT_W    (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ack"}, 32'(bus.wb_ack_o), 32'd0);
        check_eq({tag, "_err"}, 32'(bus.wb_err_o), 32'd0);
        check_eq({tag, "_dat"}, bus.wb_data_o, 32'd0);
    endtask

    // One host transaction. delay = strobe cycle (1-based) on which the
    // selected slave acks (or on which the host drops cyc when drop=1).
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, input logic [31:0] rdata,
                           input int delay, input bit drop);
        int           sel;
        int           waits;
        bit           to_exp;
        logic [N-1:0] oh;
        logic [N-1:0] noise;
        sel = int'(addr[SEL_LSB +: 2]);
        oh  = (sel < N) ? (N'(1) << sel) : '0;

        @(posedge clock); #1;
        bus.wb_cyc_i    = 1'b1;
        bus.wb_strobe_i = 1'b1;
        bus.wb_addr_i   = addr;
        bus.wb_data_i   = wdata;
        bus.wb_we_i     = we;
        bus.s_ack_i     = '0;
        for (int k = 0; k < N; k++) bus.s_data_i[32*k +: 32] = $urandom;
        if (sel < N) bus.s_data_i[32*sel +: 32] = rdata;
        @(posedge clock); #1;

        if (sel >= N) begin
            bus.wb_cyc_i    = 1'b0;
            bus.wb_strobe_i = 1'b0;
            @(negedge clock);
            check_eq("unmap_err", 32'(bus.wb_err_o), 32'd1);
            check_eq("unmap_ack", 32'(bus.wb_ack_o), 32'd0);
            check_eq("unmap_stb", 32'(bus.s_strobe_o), 32'd0);
            check_eq("unmap_cyc", 32'(bus.s_cyc_o), 32'd0);
            @(posedge clock); #1;
            @(negedge clock);
            check_quiet("unmap_after");
            return;
        end

        waits  = delay;
        to_exp = 1'b0;
`ifdef WB_XBAR_TIMEOUT_EN
        if (!drop && delay > TOUT) begin
            waits  = TOUT;
            to_exp = 1'b1;
        end
`endif
        for (int n = 1; n <= waits; n++) begin
            noise = N'($urandom) & ~oh;
            if (drop && n == waits) begin
                bus.wb_cyc_i    = 1'b0;
                bus.wb_strobe_i = 1'b0;
                bus.s_ack_i     = noise;
            end else if (!to_exp && n == waits) begin
                bus.s_ack_i = noise | oh;
            end else begin
                bus.s_ack_i = noise;
            end
            @(negedge clock);
            check_eq("wait_stb", 32'(bus.s_strobe_o), 32'(oh));
            check_eq("wait_cyc", 32'(bus.s_cyc_o), 32'(oh));
            check_quiet("wait");
            if (n == 1) begin
                check_eq("s_addr", bus.s_addr_o, addr);
                check_eq("s_data", bus.s_data_o, wdata);
                check_eq("s_we", 32'(bus.s_we_o), 32'(we));
            end
            @(posedge clock); #1;
        end
        bus.s_ack_i = '0;

        if (drop) begin
            @(negedge clock);
            check_eq("abort_stb", 32'(bus.s_strobe_o), 32'd0);
            check_quiet("abort");
            @(posedge clock); #1;
            bus.s_ack_i = oh;      // late ack after the abort
            @(negedge clock);
            check_quiet("late_ack");
            @(posedge clock); #1;
            bus.s_ack_i = '0;
            @(negedge clock);
            check_quiet("late_ack2");
            return;
        end

        bus.wb_cyc_i    = 1'b0;
        bus.wb_strobe_i = 1'b0;
        @(negedge clock);
        if (to_exp) begin
            check_eq("to_err", 32'(bus.wb_err_o), 32'd1);
            check_eq("to_ack", 32'(bus.wb_ack_o), 32'd0);
            check_eq("to_dat", bus.wb_data_o, 32'd0);
        end else begin
            check_eq("resp_ack", 32'(bus.wb_ack_o), 32'd1);
            check_eq("resp_err", 32'(bus.wb_err_o), 32'd0);
            check_eq("resp_dat", bus.wb_data_o, we ? 32'd0 : rdata);
        end
        check_eq("resp_stb", 32'(bus.s_strobe_o), 32'd0);
        check_eq("resp_cyc", 32'(bus.s_cyc_o), 32'd0);
        @(posedge clock); #1;
        @(negedge clock);
        check_quiet("post_resp");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [31:0] a;
        int          s;
        reset_n         = 1'b0;
        bus.wb_cyc_i    = 1'b0;
        bus.wb_strobe_i = 1'b0;
        bus.wb_we_i     = 1'b0;
        bus.wb_addr_i   = '0;
        bus.wb_data_i   = '0;
        bus.s_ack_i     = '0;
        bus.s_data_i    = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_quiet("rst");
        check_eq("rst_stb", 32'(bus.s_strobe_o), 32'd0);
        check_eq("rst_cyc", 32'(bus.s_cyc_o), 32'd0);
        check_eq("rst_addr", bus.s_addr_o, 32'd0);
        check_eq("rst_sdat", bus.s_data_o, 32'd0);
        check_eq("rst_we", 32'(bus.s_we_o), 32'd0);
        reset_n = 1'b1;

        // directed cases
        run_txn(32'h0001_0004, 32'h0, 1'b0, 32'hA5A5_0001, 2, 1'b0);
        run_txn(32'h0000_0010, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
        run_txn(32'h0003_0000, 32'h0, 1'b0, 32'h0, 1, 1'b0);
        run_txn(32'h0002_0020, 32'h0, 1'b0, 32'h0, 1, 1'b1);
        run_txn(32'h0002_0024, 32'h0, 1'b0, 32'h5555_AAAA, 1, 1'b0);
`ifdef WB_XBAR_TIMEOUT_EN
        run_txn(32'h0001_0100, 32'h0, 1'b0, 32'h0BAD_0BAD, 6, 1'b0);
        run_txn(32'h0001_0104, 32'h0, 1'b0, 32'h600D_600D, TOUT, 1'b0);
`endif

        // reset asserted in the middle of WAIT
        @(posedge clock); #1;
        bus.wb_cyc_i    = 1'b1;
        bus.wb_strobe_i = 1'b1;
        bus.wb_we_i     = 1'b1;
        bus.wb_addr_i   = 32'h0002_0008;
        bus.wb_data_i   = 32'hCAFE_F00D;
        @(posedge clock); #1;
        @(negedge clock);
        check_eq("mid_stb", 32'(bus.s_strobe_o), 32'b100);
        #2 reset_n = 1'b0;
        #1;
        check_eq("arst_stb", 32'(bus.s_strobe_o), 32'd0);
        check_eq("arst_cyc", 32'(bus.s_cyc_o), 32'd0);
        check_eq("arst_addr", bus.s_addr_o, 32'd0);
        check_eq("arst_sdat", bus.s_data_o, 32'd0);
        check_eq("arst_we", 32'(bus.s_we_o), 32'd0);
        check_quiet("arst");
        bus.wb_cyc_i    = 1'b0;
        bus.wb_strobe_i = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_txn(32'h0002_000C, 32'h0, 1'b0, 32'h0F0F_1234, 2, 1'b0);

        // randomized transactions
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = $urandom_range(0, 3);
            a[SEL_LSB +: 2] = 2'(s);
            run_txn(a, $urandom, 1'($urandom_range(0, 1)), $urandom,
                    $urandom_range(1, 3), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
